// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq: MMC3 scanline counter with filtered PPU A12 clocking, IRQ and save-state port
module mmc3_scanline_irq #(
  parameter int A12_LOW_MIN = 64,
  parameter int LOWCNT_W    = 8
) (
  input  logic        clk,
  input  logic        map_rst,
  input  logic        cpu_we,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  cpu_dat,
  input  logic        ppu_a12,
  input  logic        mmc3a,
  input  logic        ss_act,
  input  logic        ss_we,
  input  logic [7:0]  ss_addr,
  input  logic [7:0]  ss_din,
  output logic        irq,
  output logic [7:0]  ss_dout
);
  localparam logic [LOWCNT_W-1:0] LOW_MAX = LOWCNT_W'(A12_LOW_MIN);
  logic [7:0] r_latch, r_counter;
  logic r_reload, r_irq_en, r_irq_pend;
  logic r_s1, r_s2, r_s3;
  logic [LOWCNT_W-1:0] r_lowcnt;
  logic w_low_ok, w_a12_clk, w_c000, w_c001, w_e000, w_e001, w_fire;
  logic [7:0] w_next;
  assign w_low_ok  = r_lowcnt == LOW_MAX;
  assign w_a12_clk = r_s2 & ~r_s3 & w_low_ok;
  assign w_c000    = cpu_we & (reg_addr == 16'hC000);
  assign w_c001    = cpu_we & (reg_addr == 16'hC001);
  assign w_e000    = cpu_we & (reg_addr == 16'hE000);
  assign w_e001    = cpu_we & (reg_addr == 16'hE001);
  assign w_next    = ((r_counter == 8'd0) | r_reload) ? r_latch : r_counter - 8'd1;
  // MMC3A only fires when the counter actually transitions to zero
  assign w_fire    = (w_next == 8'd0) & (~mmc3a | (r_counter != 8'd0) | r_reload);
  assign irq       = r_irq_pend;
  always_ff @(posedge clk) begin
    if (map_rst & ~ss_act) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ppu_a12;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end
  always_ff @(posedge clk) begin
    if (ss_act) begin
      if (ss_we && ss_addr == 8'd16) r_latch <= ss_din;
      if (ss_we && ss_addr == 8'd17) r_counter <= ss_din;
      if (ss_we && ss_addr == 8'd18) {r_reload, r_irq_en, r_irq_pend} <= ss_din[2:0];
    end else if (map_rst) begin
      r_latch    <= 8'd0;
      r_counter  <= 8'd0;
      r_reload   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq_pend <= 1'b0;
      r_lowcnt   <= '0;
    end else begin
      r_lowcnt <= r_s2 ? '0 : (w_low_ok ? r_lowcnt : r_lowcnt + 1'b1);
      if (w_c000) r_latch <= cpu_dat;
      if (w_c001) begin
        r_counter <= 8'd0;
        r_reload  <= 1'b1;
      end else if (w_a12_clk) begin
        r_counter <= w_next;
        r_reload  <= 1'b0;
      end
      if (w_e000) begin
        r_irq_en   <= 1'b0;
        r_irq_pend <= 1'b0;
      end else begin
        if (w_e001) r_irq_en <= 1'b1;
        if (w_a12_clk & ~w_c001 & w_fire & r_irq_en) r_irq_pend <= 1'b1;
      end
    end
  end
  always_comb
    ss_dout = (ss_addr == 8'd16) ? r_latch :
              (ss_addr == 8'd17) ? r_counter :
              (ss_addr == 8'd18) ? {5'd0, r_reload, r_irq_en, r_irq_pend} :
              (ss_addr >= 8'd19 && ss_addr <= 8'd23) ? 8'hFF : 8'h00;
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq: directed stimulus with a queued scoreboard checked on the falling edge
module tb_mmc3_scanline_irq;
  localparam int MIN = 64;
  logic clk = 1'b0;
  logic map_rst, cpu_we, ppu_a12, mmc3a, ss_act, ss_we, irq;
  logic [15:0] reg_addr;
  logic [7:0] cpu_dat, ss_addr, ss_din, ss_dout;
  typedef struct {string name; bit is_irq; logic [7:0] exp;} chk_t;
  chk_t q[$];
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  mmc3_scanline_irq #(.A12_LOW_MIN(MIN), .LOWCNT_W(8)) dut (
    .clk(clk), .map_rst(map_rst), .cpu_we(cpu_we), .reg_addr(reg_addr), .cpu_dat(cpu_dat),
    .ppu_a12(ppu_a12), .mmc3a(mmc3a), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
    .ss_din(ss_din), .irq(irq), .ss_dout(ss_dout)
  );
  initial forever begin
    @(negedge clk);
    while (q.size() > 0) begin
      chk_t c;
      logic [7:0] act;
      c = q.pop_front();
      act = c.is_irq ? {7'd0, irq} : ss_dout;
      n_total++;
      if (act === c.exp) n_pass++;
      else $display("FAIL %s: got %02h want %02h", c.name, act, c.exp);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_irq(input logic e, input string nm);
    q.push_back('{nm, 1'b1, {7'd0, e}});
  endtask
  task automatic chk_reg(input logic [7:0] a, input logic [7:0] e, input string nm);
    ss_addr = a;
    q.push_back('{nm, 1'b0, e});
    @(negedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_we = 1'b1; reg_addr = a; cpu_dat = d;
    cyc(1);
    cpu_we = 1'b0;
  endtask
  task automatic ss_wr(input logic [7:0] a, input logic [7:0] d);
    ss_we = 1'b1; ss_addr = a; ss_din = d;
    cyc(1);
    ss_we = 1'b0;
  endtask
  task automatic pulse(input int low);
    ppu_a12 = 1'b0;
    cyc(low);
    ppu_a12 = 1'b1;
    cyc(3);
  endtask
  task automatic rise_to_edge();
    ppu_a12 = 1'b0;
    cyc(MIN);
    ppu_a12 = 1'b1;
    cyc(2);
  endtask
  initial begin
    map_rst = 1'b1; cpu_we = 1'b0; reg_addr = '0; cpu_dat = '0; ppu_a12 = 1'b0;
    mmc3a = 1'b0; ss_act = 1'b0; ss_we = 1'b0; ss_addr = '0; ss_din = '0;
    cyc(3);
    map_rst = 1'b0;
    chk_irq(1'b0, "rst_irq");
    chk_reg(8'd16, 8'h00, "rst_latch");
    chk_reg(8'd17, 8'h00, "rst_counter");
    chk_reg(8'd18, 8'h00, "rst_flags");
    wr(16'hC000, 8'd3); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
    chk_reg(8'd18, 8'h06, "setup_flags");
    pulse(MIN); chk_reg(8'd17, 8'd3, "cnt_e1");
    pulse(MIN); chk_reg(8'd17, 8'd2, "cnt_e2");
    pulse(MIN); chk_reg(8'd17, 8'd1, "cnt_e3");
    rise_to_edge();
    chk_irq(1'b0, "irq_early");
    cyc(1);
    chk_irq(1'b1, "irq_rise");
    chk_reg(8'd17, 8'd0, "cnt_e4");
    pulse(MIN); chk_irq(1'b1, "irq_hold"); chk_reg(8'd17, 8'd3, "cnt_e5");
    wr(16'hE000, 8'd0);
    chk_irq(1'b0, "ack_irq");
    chk_reg(8'd18, 8'h00, "ack_flags");
    pulse(MIN - 1); chk_reg(8'd17, 8'd3, "short_low");
    pulse(MIN); chk_reg(8'd17, 8'd2, "min_low");
    rise_to_edge(); wr(16'hC001, 8'd0);
    chk_reg(8'd17, 8'd0, "c001_edge_cnt");
    chk_reg(8'd18, 8'h04, "c001_edge_flags");
    pulse(MIN); chk_reg(8'd17, 8'd3, "c001_reload");
    wr(16'hC001, 8'd0);
    rise_to_edge(); wr(16'hC000, 8'd9);
    chk_reg(8'd17, 8'd3, "c000_edge_old");
    chk_reg(8'd16, 8'd9, "c000_edge_latch");
    wr(16'hC000, 8'd0); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
    pulse(MIN); chk_irq(1'b1, "b_l0_e1"); chk_reg(8'd17, 8'd0, "b_l0_cnt");
    wr(16'hE000, 8'd0); chk_irq(1'b0, "b_l0_ack"); wr(16'hE001, 8'd0);
    pulse(MIN); chk_irq(1'b1, "b_l0_e2");
    wr(16'hE000, 8'd0); wr(16'hE001, 8'd0);
    pulse(MIN); chk_irq(1'b1, "b_l0_e3");
    mmc3a = 1'b1;
    wr(16'hE000, 8'd0); wr(16'hC001, 8'd0); wr(16'hE001, 8'd0);
    pulse(MIN); chk_irq(1'b1, "a_l0_e1");
    wr(16'hE000, 8'd0); wr(16'hE001, 8'd0);
    pulse(MIN); chk_irq(1'b0, "a_l0_e2");
    pulse(MIN); chk_irq(1'b0, "a_l0_e3");
    mmc3a = 1'b0;
    wr(16'hE000, 8'd0); wr(16'hC000, 8'd1); wr(16'hC001, 8'd0);
    pulse(MIN); chk_reg(8'd17, 8'd1, "dis_e1");
    pulse(MIN); chk_irq(1'b0, "dis_zero_irq"); chk_reg(8'd17, 8'd0, "dis_zero_cnt");
    wr(16'hE001, 8'd0); chk_irq(1'b0, "en_late_irq");
    pulse(MIN); chk_irq(1'b0, "en_reload_irq"); chk_reg(8'd17, 8'd1, "en_reload_cnt");
    pulse(MIN); chk_irq(1'b1, "en_fire");
    wr(16'hE000, 8'd0);
    pulse(MIN);
    rise_to_edge(); wr(16'hE001, 8'd0);
    chk_irq(1'b0, "e001_fire_irq");
    chk_reg(8'd18, 8'h02, "e001_fire_flags");
    ss_act = 1'b1;
    ss_wr(8'd16, 8'h20); ss_wr(8'd17, 8'h05); ss_wr(8'd18, 8'h07);
    chk_irq(1'b1, "ss_irq");
    chk_reg(8'd16, 8'h20, "ss_latch");
    chk_reg(8'd17, 8'h05, "ss_counter");
    chk_reg(8'd18, 8'h07, "ss_flags");
    wr(16'hC000, 8'h55); wr(16'hC001, 8'd0); wr(16'hE000, 8'd0);
    pulse(MIN);
    map_rst = 1'b1; cyc(1); map_rst = 1'b0;
    chk_irq(1'b1, "ss_frz_irq");
    chk_reg(8'd16, 8'h20, "ss_frz_latch");
    chk_reg(8'd17, 8'h05, "ss_frz_counter");
    chk_reg(8'd18, 8'h07, "ss_frz_flags");
    chk_reg(8'd20, 8'hFF, "ss_addr20");
    ss_act = 1'b0;
    pulse(MIN); chk_reg(8'd17, 8'h20, "ss_resume");
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc(1);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
